// File: rtl/spike_event_detector_if.sv
// spike_event_detector_if
//   Event stream from spike_event_detector to its consumer.
//   ev_valid : FIFO head holds an event
//   ev_ready : consumer accepts the head when ev_valid & ev_ready
//   ev_isi   : inter-spike interval of the head event, in samples
//   ev_peak  : signed peak voltage of the head event
//   master modport = detector side, slave modport = consumer side.
interface spike_event_detector_if #(
    parameter int WIDTH = 27,
    parameter int ISI_W = 16
);
    logic                    ev_valid;
    logic                    ev_ready;
    logic [ISI_W-1:0]        ev_isi;
    logic signed [WIDTH-1:0] ev_peak;

    modport master (output ev_valid, output ev_isi, output ev_peak, input ev_ready);
    modport slave  (input ev_valid, input ev_isi, input ev_peak, output ev_ready);
endinterface

// File: rtl/spike_event_detector.sv
// spike_event_detector
//   Samples a membrane-voltage stream on each v_valid strobe, detects spikes by
//   threshold crossing with hysteresis, and queues one {ISI, peak} record per
//   spike in a small FIFO drained over a valid/ready handshake.
//
//   Ports
//     clk        : clock, rising edge
//     rst        : synchronous active-high reset
//     v_in       : signed membrane voltage
//     v_valid    : sample strobe, one sample accepted per high cycle
//     ev         : event stream (master modport of spike_event_detector_if)
//     spike_cnt  : onsets detected since reset, wraps modulo 2^16
//     drop_cnt   : events lost to a full FIFO, saturates at 255
//
//   Build option
//     SPIKE_DET_PEAK_EN : when defined, peak tracking and the FIFO peak field
//                         are built; otherwise ev_peak is tied to 0.
//
//   State table
//     state | meaning
//     BELOW | no spike in progress, waiting for a sample >= V_TH
//     ABOVE | spike in progress, waiting for a sample < V_TH - HYST
module spike_event_detector #(
    parameter int          WIDTH = 27,
    parameter int signed   V_TH  = 0,
    parameter int unsigned HYST  = 100,
    parameter int          ISI_W = 16,
    parameter int          DEPTH = 4      // power of two, at least 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] v_in,
    input  logic                    v_valid,
    spike_event_detector_if.master  ev,
    output logic [15:0]             spike_cnt,
    output logic [7:0]              drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [ISI_W-1:0]        ISI_MAX = '1;
    localparam logic signed [WIDTH-1:0] V_HI    = WIDTH'(V_TH);
    // Offset threshold is one bit wider than the sample so V_TH - HYST never wraps.
    localparam logic signed [WIDTH:0]   V_LO    =
        $signed((WIDTH+1)'(V_TH)) - $signed((WIDTH+1)'(HYST));

    typedef enum logic {
        BELOW = 1'b0,
        ABOVE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             first_q, first_d;
    logic [ISI_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [ISI_W-1:0] isi_lat_q, isi_lat_d;
    logic [15:0]      spike_cnt_q, spike_cnt_d;
    logic [7:0]       drop_cnt_q, drop_cnt_d;
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [ISI_W-1:0] isi_mem_q [DEPTH];

`ifdef SPIKE_DET_PEAK_EN
    logic signed [WIDTH-1:0] peak_q, peak_d;
    logic signed [WIDTH-1:0] peak_mem_q [DEPTH];
`endif

    logic signed [WIDTH:0] v_ext;
    logic [ISI_W-1:0]      isi_inc;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  pop;
    logic                  push_req;
    logic                  push_ok;

    assign v_ext      = {v_in[WIDTH-1], v_in};
    assign isi_inc    = (isi_cnt_q == ISI_MAX) ? ISI_MAX : isi_cnt_q + ISI_W'(1);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    // pop depends only on registered emptiness, so ev_ready never reaches ev_valid.
    assign pop        = !fifo_empty && ev.ev_ready;

    always_comb begin
        state_d     = state_q;
        first_d     = first_q;
        isi_cnt_d   = isi_cnt_q;
        isi_lat_d   = isi_lat_q;
        spike_cnt_d = spike_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        push_req    = 1'b0;
        push_ok     = 1'b0;
`ifdef SPIKE_DET_PEAK_EN
        peak_d      = peak_q;
`endif

        if (v_valid) begin
            unique case (state_q)
                BELOW: begin
                    if (v_in >= V_HI) begin
                        state_d     = ABOVE;
                        spike_cnt_d = spike_cnt_q + 16'd1;
                        // First onset has no predecessor, so its interval is 0.
                        isi_lat_d   = first_q ? '0 : isi_inc;
                        first_d     = 1'b0;
                        isi_cnt_d   = '0;
`ifdef SPIKE_DET_PEAK_EN
                        peak_d      = v_in;
`endif
                    end else begin
                        isi_cnt_d = isi_inc;
                    end
                end
                ABOVE: begin
                    isi_cnt_d = isi_inc;
                    if (v_ext < V_LO) begin
                        state_d  = BELOW;
                        push_req = 1'b1;
                    end
`ifdef SPIKE_DET_PEAK_EN
                    else if (v_in > peak_q) begin
                        peak_d = v_in;
                    end
`endif
                end
                default: state_d = BELOW;
            endcase
        end

        // A push into a full FIFO still lands when the head leaves in the same cycle.
        push_ok = push_req && (!fifo_full || pop);
        if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (push_req && !push_ok && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BELOW;
            first_q     <= 1'b1;
            isi_cnt_q   <= '0;
            isi_lat_q   <= '0;
            spike_cnt_q <= '0;
            drop_cnt_q  <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
`ifdef SPIKE_DET_PEAK_EN
            peak_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            first_q     <= first_d;
            isi_cnt_q   <= isi_cnt_d;
            isi_lat_q   <= isi_lat_d;
            spike_cnt_q <= spike_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
`ifdef SPIKE_DET_PEAK_EN
            peak_q      <= peak_d;
`endif
        end
    end

    // Storage needs no reset: entries are only visible between push and pop.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            isi_mem_q[wr_ptr_q[AW-1:0]]  <= isi_lat_q;
`ifdef SPIKE_DET_PEAK_EN
            peak_mem_q[wr_ptr_q[AW-1:0]] <= peak_q;
`endif
        end
    end

    // Head fields are forced to 0 while empty so reset values are defined.
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_isi   = fifo_empty ? '0 : isi_mem_q[rd_ptr_q[AW-1:0]];
`ifdef SPIKE_DET_PEAK_EN
    assign ev.ev_peak  = fifo_empty ? '0 : peak_mem_q[rd_ptr_q[AW-1:0]];
`else
    assign ev.ev_peak  = '0;
`endif

    assign spike_cnt = spike_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_spike_event_detector.sv
module tb_spike_event_detector;

    localparam int WIDTH = 27;
    localparam int ISI_W = 16;
    localparam int DEPTH = 4;
    localparam longint V_TH = 0;
    localparam longint HYST = 100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    v_valid;
    logic signed [WIDTH-1:0] v_in;
    logic [15:0]             spike_cnt;
    logic [7:0]              drop_cnt;

    spike_event_detector_if #(.WIDTH(WIDTH), .ISI_W(ISI_W)) ev_if ();

    spike_event_detector #(
        .WIDTH(WIDTH), .V_TH(0), .HYST(100), .ISI_W(ISI_W), .DEPTH(DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .v_in     (v_in),
        .v_valid  (v_valid),
        .ev       (ev_if),
        .spike_cnt(spike_cnt),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: spike rules expressed on sample indices and a queue.
    typedef struct {
        longint isi;
        longint peak;
    } ev_t;

    ev_t    exp_q[$];
    bit     m_above;
    bit     m_first;
    longint m_idx;
    longint m_last;
    longint m_peak;
    longint m_isi;
    longint m_spikes;
    longint m_drops;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic longint exp_peak(input longint p);
`ifdef SPIKE_DET_PEAK_EN
        return p;
`else
        return 0;
`endif
    endfunction

    task automatic model_clear();
        exp_q.delete();
        m_above  = 1'b0;
        m_first  = 1'b1;
        m_idx    = 0;
        m_last   = 0;
        m_peak   = 0;
        m_isi    = 0;
        m_spikes = 0;
        m_drops  = 0;
    endtask

    task automatic model_step(input bit vv, input longint v, input bit rdy);
        bit  pop_now;
        bit  push_now;
        ev_t e;
        pop_now  = rdy && (exp_q.size() > 0);
        push_now = 1'b0;
        if (vv) begin
            m_idx++;
            if (!m_above) begin
                if (v >= V_TH) begin
                    m_above  = 1'b1;
                    m_spikes = (m_spikes + 1) % 65536;
                    m_isi    = m_first ? 0 :
                               ((m_idx - m_last) > 65535 ? 65535 : (m_idx - m_last));
                    m_last   = m_idx;
                    m_first  = 1'b0;
                    m_peak   = v;
                end
            end else if (v < V_TH - HYST) begin
                m_above  = 1'b0;
                push_now = 1'b1;
            end else if (v > m_peak) begin
                m_peak = v;
            end
        end
        if (pop_now) void'(exp_q.pop_front());
        if (push_now) begin
            if (exp_q.size() < DEPTH) begin
                e.isi  = m_isi;
                e.peak = exp_peak(m_peak);
                exp_q.push_back(e);
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("ev_valid", ev_if.ev_valid, (exp_q.size() > 0) ? 1 : 0);
        if (exp_q.size() > 0) begin
            chk("ev_isi", ev_if.ev_isi, exp_q[0].isi);
            chk("ev_peak", ev_if.ev_peak, exp_q[0].peak);
        end
        chk("spike_cnt", spike_cnt, m_spikes);
        chk("drop_cnt", drop_cnt, m_drops);
    endtask

    task automatic cyc(input bit vv, input longint v, input bit rdy);
        @(negedge clk);
        check_outputs();
        v_valid        = vv;
        v_in           = v[WIDTH-1:0];
        ev_if.ev_ready = rdy;
        model_step(vv, v, rdy);
        @(posedge clk);
    endtask

    task automatic sample(input longint v, input bit rdy, input int max_gap);
        repeat ($urandom_range(max_gap)) cyc(1'b0, longint'($urandom_range(2000)) - 1000, rdy);
        cyc(1'b1, v, rdy);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        v_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        chk("rst_ev_valid", ev_if.ev_valid, 0);
        chk("rst_ev_isi", ev_if.ev_isi, 0);
        chk("rst_ev_peak", ev_if.ev_peak, 0);
        chk("rst_spike_cnt", spike_cnt, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
    endtask

    longint isi_seq[12] = '{-500, -500, -500, 200, -200, -500, -500, -500, -500, -500, 300, -300};

    initial begin
        rst            = 1'b1;
        v_valid        = 1'b0;
        v_in           = '0;
        ev_if.ev_ready = 1'b0;
        model_clear();
        do_reset();

        // First spike, event held by backpressure for direct inspection.
        sample(-500, 0, 0);
        sample(200, 0, 0);
        sample(800, 0, 0);
        sample(300, 0, 0);
        sample(-200, 0, 0);
        #1;
        chk("first_valid", ev_if.ev_valid, 1);
        chk("first_isi", ev_if.ev_isi, 0);
        chk("first_peak", ev_if.ev_peak, exp_peak(800));
        chk("first_spike_cnt", spike_cnt, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);

        // ISI across idle gaps: onsets at sample indices 3 and 10.
        do_reset();
        foreach (isi_seq[i]) sample(isi_seq[i], 0, 3);
        cyc(0, 0, 0);
        #1;
        chk("isi_first_head", ev_if.ev_isi, 0);
        cyc(0, 0, 1);
        #1;
        chk("isi_second", ev_if.ev_isi, 7);
        chk("isi_second_peak", ev_if.ev_peak, exp_peak(300));
        cyc(0, 0, 1);
        cyc(0, 0, 1);

        // Hysteresis: -50 stays inside the band.
        do_reset();
        sample(-500, 0, 0);
        sample(200, 0, 0);
        sample(-50, 0, 0);
        sample(150, 0, 0);
        sample(-150, 0, 0);
        cyc(0, 0, 0);
        #1;
        chk("hyst_spike_cnt", spike_cnt, 1);
        chk("hyst_peak", ev_if.ev_peak, exp_peak(200));
        cyc(0, 0, 1);
        #1;
        chk("hyst_single_event", ev_if.ev_valid, 0);

        // Backpressure: six spikes into a 4-deep FIFO, then drain.
        do_reset();
        sample(-500, 0, 0);
        repeat (6) begin
            sample(300, 0, 1);
            sample(-300, 0, 1);
        end
        #1;
        chk("bp_drop_cnt", drop_cnt, 2);
        repeat (4) cyc(0, 0, 1);
        #1;
        chk("bp_drained", ev_if.ev_valid, 0);

        // Randomized traffic with random backpressure.
        do_reset();
        repeat (2000) begin
            cyc($urandom_range(3) != 0, longint'($urandom_range(2000)) - 1000,
                $urandom_range(3) != 0);
        end
        repeat (8) cyc(0, 0, 1);

        // ISI saturation.
        do_reset();
        cyc(1, -500, 1);
        cyc(1, 300, 1);
        cyc(1, -500, 1);
        repeat (70000) cyc(1, -500, 1);
        cyc(1, 300, 1);
        cyc(1, -300, 0);
        #1;
        chk("sat_valid", ev_if.ev_valid, 1);
        chk("sat_isi", ev_if.ev_isi, 65535);
        cyc(0, 0, 1);

        // Reset while ABOVE with two events queued.
        do_reset();
        sample(300, 0, 0);
        sample(-300, 0, 0);
        sample(300, 0, 0);
        sample(-300, 0, 0);
        sample(300, 0, 0);
        #1;
        chk("pre_rst_valid", ev_if.ev_valid, 1);
        chk("pre_rst_spikes", spike_cnt, 3);
        do_reset();
        cyc(1, -200, 1);
        cyc(0, 0, 1);
        cyc(0, 0, 1);
        #1;
        chk("post_rst_no_event", ev_if.ev_valid, 0);

        @(negedge clk);
        check_outputs();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
